// File: rtl/cpu_pkg.sv
// cpu_pkg - definitions shared by the CPU control blocks.
//   - Instruction-control opcodes that cause CALL/RET traffic into the
//     return-address stack.
//   - Default PC width.
//   - clog2_depth(): index width for a power-of-two storage depth.
//   - stk_op_e: per-cycle operation chosen by the call stack controller.
package cpu_pkg;

    localparam logic [3:0] OPC_RET  = 4'b0001;
    localparam logic [3:0] OPC_CALL = 4'b0011;

    localparam int DEFAULT_AW = 8;

    // Number of bits needed to index 'depth' entries (depth >= 2).
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Operation chosen for the current cycle after flush priority.
    typedef enum logic [2:0] {
        STK_IDLE    = 3'd0,
        STK_PUSH    = 3'd1,
        STK_POP     = 3'd2,
        STK_REPLACE = 3'd3,
        STK_FLUSH   = 3'd4
    } stk_op_e;

endpackage

// File: rtl/cstk_mem.sv
// cstk_mem - DEPTH x AW register array for the return-address stack.
// One synchronous write port and one asynchronous read port. The
// contents are not reset; the controller never reads an entry it has
// not written.
// Ports:
//   clk    : clock, write on rising edge
//   we     : write enable
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : read data, combinational from raddr
module cstk_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = DEFAULT_AW
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [clog2_depth(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]                 wdata,
    input  logic [clog2_depth(DEPTH)-1:0] raddr,
    output logic [AW-1:0]                 rdata
);

    logic [AW-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl - hardware return-address stack for CALL/RET.
// Circular LIFO of DEPTH return addresses. A pop returns the newest
// entry on ret_addr with ret_valid one cycle later; popping an empty
// stack pulses ret_err instead. Overflow and underflow are recorded in
// sticky flags so the pipeline never has to stall on the stack.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : CALL strobe, stores push_addr
//   pop         : RET strobe
//   push_addr   : return address to store
//   flush       : discard all entries (highest priority)
//   clr_err     : clear ovf/udf (a simultaneous set wins)
//   ret_addr    : popped address, registered, holds between pops
//   ret_valid   : one-cycle pulse, ret_addr valid
//   ret_err     : one-cycle pulse, pop on empty stack
//   count       : valid entries, 0..DEPTH
//   empty/full  : decoded from count
//   ovf/udf     : sticky overflow/underflow
module call_stack_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = DEFAULT_AW,
    parameter bit OVERWRITE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [AW-1:0]                 push_addr,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic [AW-1:0]                 ret_addr,
    output logic                          ret_valid,
    output logic                          ret_err,
    output logic [clog2_depth(DEPTH):0]   count,
    output logic                          empty,
    output logic                          full,
    output logic                          ovf,
    output logic                          udf
);

    localparam int PW = clog2_depth(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = '0;
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

    // State
    logic [PW-1:0] top_reg,       top_next;
    logic [CW-1:0] count_reg,     count_next;
    logic [AW-1:0] ret_addr_reg,  ret_addr_next;
    logic          ret_valid_reg, ret_valid_next;
    logic          ret_err_reg,   ret_err_next;
    logic          ovf_reg,       ovf_next;
    logic          udf_reg,       udf_next;

    // Storage interface
    logic          mem_we;
    logic [PW-1:0] mem_waddr;
    logic [PW-1:0] top_minus1;
    logic [AW-1:0] mem_rdata;

    logic    empty_int;
    logic    full_int;
    logic    ovf_set;
    logic    udf_set;
    stk_op_e stk_op;

    assign empty_int  = (count_reg == CNT_ZERO);
    assign full_int   = (count_reg == CNT_FULL);
    assign top_minus1 = top_reg - PTR_ONE;

    cstk_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_addr),
        .raddr (top_minus1),
        .rdata (mem_rdata)
    );

    // Operation decode: flush masks push/pop entirely.
    always_comb begin
        stk_op = STK_IDLE;
        if (flush) begin
            stk_op = STK_FLUSH;
        end else if (push && pop) begin
            stk_op = STK_REPLACE;
        end else if (pop) begin
            stk_op = STK_POP;
        end else if (push) begin
            stk_op = STK_PUSH;
        end
    end

    always_comb begin
        top_next       = top_reg;
        count_next     = count_reg;
        ret_addr_next  = ret_addr_reg;
        ret_valid_next = 1'b0;
        ret_err_next   = 1'b0;
        ovf_set        = 1'b0;
        udf_set        = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = top_reg;

        unique case (stk_op)
            STK_FLUSH: begin
                // Entries are discarded by zeroing count; top is left
                // where it is since occupancy alone defines validity.
                count_next = CNT_ZERO;
            end
            STK_REPLACE: begin
                if (empty_int) begin
                    // Nothing to pop: report the underflow, but the
                    // call still lands as an ordinary push.
                    ret_err_next = 1'b1;
                    udf_set      = 1'b1;
                    mem_we       = 1'b1;
                    top_next     = top_reg + PTR_ONE;
                    count_next   = count_reg + CNT_ONE;
                end else begin
                    // Return the current top and overwrite it in place.
                    ret_valid_next = 1'b1;
                    ret_addr_next  = mem_rdata;
                    mem_we         = 1'b1;
                    mem_waddr      = top_minus1;
                end
            end
            STK_POP: begin
                if (empty_int) begin
                    ret_err_next = 1'b1;
                    udf_set      = 1'b1;
                end else begin
                    ret_valid_next = 1'b1;
                    ret_addr_next  = mem_rdata;
                    top_next       = top_minus1;
                    count_next     = count_reg - CNT_ONE;
                end
            end
            STK_PUSH: begin
                if (!full_int) begin
                    mem_we     = 1'b1;
                    top_next   = top_reg + PTR_ONE;
                    count_next = count_reg + CNT_ONE;
                end else begin
                    ovf_set = 1'b1;
                    if (OVERWRITE) begin
                        // Writing at top when full lands on the oldest
                        // slot; count stays saturated at DEPTH.
                        mem_we   = 1'b1;
                        top_next = top_reg + PTR_ONE;
                    end
                end
            end
            default: begin
            end
        endcase

        // Set beats clear.
        ovf_next = ovf_set | (ovf_reg & ~clr_err);
        udf_next = udf_set | (udf_reg & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_reg       <= '0;
            count_reg     <= '0;
            ret_addr_reg  <= '0;
            ret_valid_reg <= 1'b0;
            ret_err_reg   <= 1'b0;
            ovf_reg       <= 1'b0;
            udf_reg       <= 1'b0;
        end else begin
            top_reg       <= top_next;
            count_reg     <= count_next;
            ret_addr_reg  <= ret_addr_next;
            ret_valid_reg <= ret_valid_next;
            ret_err_reg   <= ret_err_next;
            ovf_reg       <= ovf_next;
            udf_reg       <= udf_next;
        end
    end

    assign ret_addr  = ret_addr_reg;
    assign ret_valid = ret_valid_reg;
    assign ret_err   = ret_err_reg;
    assign count     = count_reg;
    assign empty     = empty_int;
    assign full      = full_int;
    assign ovf       = ovf_reg;
    assign udf       = udf_reg;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl - directed bench for call_stack_ctrl.
// Two instances share all inputs: u_ow (OVERWRITE=1) and u_nw
// (OVERWRITE=0). They behave identically except when pushing into a
// full stack. Outputs are sampled 1 ns after the rising edge.
module tb_call_stack_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 8;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_addr;
    logic          flush;
    logic          clr_err;

    logic [AW-1:0] ow_ret_addr, nw_ret_addr;
    logic          ow_ret_valid, nw_ret_valid;
    logic          ow_ret_err, nw_ret_err;
    logic [3:0]    ow_count, nw_count;
    logic          ow_empty, nw_empty;
    logic          ow_full, nw_full;
    logic          ow_ovf, nw_ovf;
    logic          ow_udf, nw_udf;

    int n_checks = 0;
    int n_pass   = 0;

    call_stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .OVERWRITE(1'b1)) u_ow (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .push_addr(push_addr), .flush(flush), .clr_err(clr_err),
        .ret_addr(ow_ret_addr), .ret_valid(ow_ret_valid), .ret_err(ow_ret_err),
        .count(ow_count), .empty(ow_empty), .full(ow_full),
        .ovf(ow_ovf), .udf(ow_udf)
    );

    call_stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .OVERWRITE(1'b0)) u_nw (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .push_addr(push_addr), .flush(flush), .clr_err(clr_err),
        .ret_addr(nw_ret_addr), .ret_valid(nw_ret_valid), .ret_err(nw_ret_err),
        .count(nw_count), .empty(nw_empty), .full(nw_full),
        .ovf(nw_ovf), .udf(nw_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, wait for the edge, sample at +1 ns.
    task automatic cyc(input logic p_push, input logic p_pop, input logic [AW-1:0] p_addr,
                       input logic p_flush, input logic p_clr);
        push      = p_push;
        pop       = p_pop;
        push_addr = p_addr;
        flush     = p_flush;
        clr_err   = p_clr;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        $display("cyc t=%0t push=%0d pop=%0d addr=%02h flush=%0d clr=%0d -> ret=%02h v=%0d e=%0d cnt=%0d ovf=%0d udf=%0d",
                 $time, p_push, p_pop, p_addr, p_flush, p_clr,
                 ow_ret_addr, ow_ret_valid, ow_ret_err, ow_count, ow_ovf, ow_udf);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
        flush = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_count",     32'(ow_count), 32'd0);
        check("rst_empty",     32'(ow_empty), 32'd1);
        check("rst_full",      32'(ow_full), 32'd0);
        check("rst_ret_addr",  32'(ow_ret_addr), 32'h00);
        check("rst_ret_valid", 32'(ow_ret_valid), 32'd0);
        check("rst_ret_err",   32'(ow_ret_err), 32'd0);
        check("rst_ovf",       32'(ow_ovf), 32'd0);
        check("rst_udf",       32'(ow_udf), 32'd0);
        rst_n = 1'b1;

        // Push three, pop three back to back
        cyc(1, 0, 8'h10, 0, 0);
        check("p1_valid", 32'(ow_ret_valid), 32'd0);
        cyc(1, 0, 8'h20, 0, 0);
        cyc(1, 0, 8'h30, 0, 0);
        check("p3_count", 32'(ow_count), 32'd3);
        cyc(0, 1, 8'h00, 0, 0);
        check("pop1_valid", 32'(ow_ret_valid), 32'd1);
        check("pop1_addr",  32'(ow_ret_addr), 32'h30);
        cyc(0, 1, 8'h00, 0, 0);
        check("pop2_valid", 32'(ow_ret_valid), 32'd1);
        check("pop2_addr",  32'(ow_ret_addr), 32'h20);
        cyc(0, 1, 8'h00, 0, 0);
        check("pop3_valid", 32'(ow_ret_valid), 32'd1);
        check("pop3_addr",  32'(ow_ret_addr), 32'h10);
        check("pop3_count", 32'(ow_count), 32'd0);
        check("pop3_empty", 32'(ow_empty), 32'd1);
        cyc(0, 0, 8'h00, 0, 0);
        check("idle_valid", 32'(ow_ret_valid), 32'd0);

        // Underflow
        cyc(0, 1, 8'h00, 0, 0);
        check("udf_err",   32'(ow_ret_err), 32'd1);
        check("udf_valid", 32'(ow_ret_valid), 32'd0);
        check("udf_flag",  32'(ow_udf), 32'd1);
        check("udf_addr_hold", 32'(ow_ret_addr), 32'h10);
        cyc(0, 0, 8'h00, 0, 0);
        check("udf_err_pulse", 32'(ow_ret_err), 32'd0);
        check("udf_sticky",    32'(ow_udf), 32'd1);
        cyc(0, 0, 8'h00, 0, 1);
        check("udf_clr", 32'(ow_udf), 32'd0);

        // Fill past full: 0x01..0x09
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 8'(i), 0, 0);
        end
        check("fill_full", 32'(ow_full), 32'd1);
        check("fill_ovf",  32'(ow_ovf), 32'd0);
        cyc(1, 0, 8'h09, 0, 0);
        check("ow_ovf",   32'(ow_ovf), 32'd1);
        check("nw_ovf",   32'(nw_ovf), 32'd1);
        check("ow_count", 32'(ow_count), 32'd8);
        check("nw_count", 32'(nw_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 8'h00, 0, 0);
            check("ow_pop_addr", 32'(ow_ret_addr), 32'(9 - i));
            check("nw_pop_addr", 32'(nw_ret_addr), 32'(8 - i));
            check("ow_pop_cnt",  32'(ow_count), 32'(7 - i));
        end
        check("ovf_sticky_ow", 32'(ow_ovf), 32'd1);
        check("ovf_sticky_nw", 32'(nw_ovf), 32'd1);
        // Set wins over clear: push into empty is no overflow, so
        // check clear alone, then a set+clear with a full stack later.
        cyc(0, 0, 8'h00, 0, 1);
        check("ovf_clr", 32'(ow_ovf), 32'd0);

        // Replace-top
        cyc(1, 0, 8'hA0, 0, 0);
        cyc(1, 1, 8'hB0, 0, 0);
        check("rep_valid", 32'(ow_ret_valid), 32'd1);
        check("rep_addr",  32'(ow_ret_addr), 32'hA0);
        check("rep_count", 32'(ow_count), 32'd1);
        cyc(0, 1, 8'h00, 0, 0);
        check("rep_pop_addr",  32'(ow_ret_addr), 32'hB0);
        check("rep_pop_count", 32'(ow_count), 32'd0);

        // Push+pop on empty: error plus push
        cyc(1, 1, 8'h77, 0, 0);
        check("pe_err",   32'(ow_ret_err), 32'd1);
        check("pe_valid", 32'(ow_ret_valid), 32'd0);
        check("pe_count", 32'(ow_count), 32'd1);
        cyc(0, 1, 8'h00, 0, 1);
        check("pe_pop_addr", 32'(ow_ret_addr), 32'h77);
        check("pe_udf_clr",  32'(ow_udf), 32'd0);

        // Flush with pop
        cyc(1, 0, 8'h11, 0, 0);
        cyc(1, 0, 8'h22, 0, 0);
        cyc(0, 1, 8'h00, 1, 0);
        check("fl_valid", 32'(ow_ret_valid), 32'd0);
        check("fl_err",   32'(ow_ret_err), 32'd0);
        check("fl_count", 32'(ow_count), 32'd0);
        check("fl_empty", 32'(ow_empty), 32'd1);

        // Set beats clear: overflow with clr_err in the same cycle
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 8'(8'h40 + i), 0, 0);
        end
        cyc(1, 0, 8'h50, 0, 1);
        check("set_wins_ovf", 32'(ow_ovf), 32'd1);
        cyc(0, 0, 8'h00, 1, 0);

        // Async reset mid-operation
        cyc(0, 1, 8'h00, 0, 0);
        check("pre_rst_udf", 32'(ow_udf), 32'd1);
        cyc(1, 0, 8'h55, 0, 0);
        cyc(1, 0, 8'h66, 0, 0);
        pop = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(ow_ret_valid), 32'd1);
        check("pre_rst_addr",  32'(ow_ret_addr), 32'h66);
        #2;
        rst_n = 1'b0;
        #1;
        pop = 1'b0;
        check("arst_valid", 32'(ow_ret_valid), 32'd0);
        check("arst_addr",  32'(ow_ret_addr), 32'h00);
        check("arst_count", 32'(ow_count), 32'd0);
        check("arst_udf",   32'(ow_udf), 32'd0);
        check("arst_ovf",   32'(ow_ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 8'h00, 0, 0);
        check("post_rst_valid", 32'(ow_ret_valid), 32'd0);
        check("post_rst_err",   32'(ow_ret_err), 32'd0);
        check("post_rst_empty", 32'(ow_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
